// File: rtl/board_input_conditioner.sv
// board_input_conditioner: synchronise, polarity-correct and debounce board inputs into clean levels,
// single-cycle edge pulses and sticky rise events with a maskable interrupt.
module board_input_conditioner #(
    parameter int unsigned      NumIn          = 20,
    parameter int unsigned      SyncStages     = 2,
    parameter int unsigned      DebounceCycles = 500000,
    parameter logic [NumIn-1:0] InvertMask     = '0
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [NumIn-1:0] raw_i,
    output logic [NumIn-1:0] level_o,
    output logic [NumIn-1:0] rise_o,
    output logic [NumIn-1:0] fall_o,
    output logic [NumIn-1:0] event_o,
    input  logic [NumIn-1:0] event_clr_i,
    input  logic [NumIn-1:0] irq_en_i,
    output logic             irq_o
);
    localparam int unsigned CntW = $clog2(DebounceCycles + 1);

    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_e;

    logic [SyncStages-1:0][NumIn-1:0] sync_q;
    logic [NumIn-1:0]                 s;

    // Reset to the inactive raw level so active-low inputs read idle as 0.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) sync_q <= {SyncStages{InvertMask}};
        else             sync_q <= {sync_q[SyncStages-2:0], raw_i};
    end

    assign s = sync_q[SyncStages-1] ^ InvertMask;

    for (genvar g = 0; g < NumIn; g++) begin : g_ch
        state_e          state_q;
        logic [CntW-1:0] cnt_q;
        logic            level_q;
        logic            rise_q;
        logic            fall_q;
        always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                case (state_q)
                    STABLE_LO: if (s[g]) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= CntW'(1);
                    end
                    WAIT_HI: if (!s[g]) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntW'(DebounceCycles)) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                    STABLE_HI: if (!s[g]) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= CntW'(1);
                    end
                    WAIT_LO: if (s[g]) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntW'(DebounceCycles)) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                    default: state_q <= STABLE_LO;
                endcase
            end
        end
        assign level_o[g] = level_q;
        assign rise_o[g]  = rise_q;
        assign fall_o[g]  = fall_q;
    end

    // A rise arriving together with a clear keeps the flag set.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) event_o <= '0;
        else             event_o <= rise_o | (event_o & ~event_clr_i);
    end

    assign irq_o = |(event_o & irq_en_i);
endmodule

// File: doc/board_input_conditioner.md
# board_input_conditioner

Parametrised conditioning stage between raw board inputs (slide switches, push buttons) and the demo system's general-purpose input bus. Each of `NumIn` channels is synchronised, optionally inverted, and debounced by a per-channel counter. Each channel produces a clean level, single-cycle rise/fall pulses and a sticky rise-event flag with maskable interrupt. It replaces direct wiring of `{SW, BTN}` into `gp_i` in board tops and adds the debounce and event behaviour that direct wiring lacks.

## Interface
Parameters:
- `NumIn`, 20, number of input channels (≥1).
- `SyncStages`, 2, synchroniser flops per channel (≥2).
- `DebounceCycles`, 500000, consecutive cycles a new value must persist (≥1). Equals 5 ms at 100 MHz.
- `InvertMask`, '0, NumIn bits; bit=1 marks an active-low input, which is inverted after synchronisation.

Ports:
- `clk_sys_i`, in, 1, system clock.
- `rst_sys_ni`, in, 1, reset. Asynchronous, active-low.
- `raw_i`, in, NumIn, asynchronous board inputs.
- `level_o`, out, NumIn, debounced, polarity-corrected levels; feeds `gp_i`.
- `rise_o`, out, NumIn, one-cycle pulse when `level_o[i]` goes 0→1.
- `fall_o`, out, NumIn, one-cycle pulse when `level_o[i]` goes 1→0.
- `event_o`, out, NumIn, sticky flag, set by `rise_o[i]`.
- `event_clr_i`, in, NumIn, write-1-to-clear for `event_o`, sampled each cycle.
- `irq_en_i`, in, NumIn, per-channel interrupt enable.
- `irq_o`, out, 1, equals `|(event_o & irq_en_i)`. Purely combinational from registered state.

## Operation
- Synchroniser:
  - Each `raw_i[i]` passes through `SyncStages` flops.
  - The synchroniser flops reset to `InvertMask[i]`, so the idle level of an active-low input reads as 0.
  - The sync output is XORed with `InvertMask[i]` to give `s[i]`.
- Per-channel FSM with 4 states:
  - STABLE_LO: `level`=0. If `s`=1, go to WAIT_HI with count=1.
  - WAIT_HI: `level`=0.
    - If `s`=0, return to STABLE_LO with count=0 (glitch rejected).
    - If `s`=1 and count==DebounceCycles, go to STABLE_HI, set `level`=1, pulse `rise`.
    - Otherwise count++.
  - STABLE_HI and WAIT_LO: mirror of the two states above. The exit from WAIT_LO pulses `fall`.
- With `DebounceCycles`=1, WAIT_* exits on the next cycle if `s` still differs. The WAIT state is always visited for at least one cycle.
- Counter width is `$clog2(DebounceCycles+1)`. The counter saturates and never wraps, because the FSM exits at the terminal count.
- Events:
  - `event_o[i]` sets on `rise_o[i]`.
  - `event_o[i]` clears on `event_clr_i[i]`.
  - If set and clear occur in the same cycle, set wins.
- Channels are fully independent. There is no shared state other than the `irq_o` OR-reduction.

## Timing
- Reset values:
  - `level_o`, `rise_o`, `fall_o`, `event_o` all 0; `irq_o`=0.
  - All FSMs in STABLE_LO; all counters 0.
- Latency:
  - A clean edge on `raw_i[i]` first sampled at clock edge E reaches `s[i]` at E+SyncStages−1.
  - `level_o[i]` and the rise/fall pulse update at edge E+SyncStages−1+DebounceCycles+1. This is E+SyncStages+DebounceCycles.
- `rise_o`/`fall_o` are high for exactly one cycle, coincident with the first cycle of the new `level_o`.
- `event_o` updates one cycle after `rise_o`.
- `irq_o` follows `event_o` in the same cycle.
- A pulse on `raw_i` shorter than `DebounceCycles` cycles (post-sync) never changes `level_o`.
- Reset asserted mid-debounce: all state returns to reset values immediately (asynchronously). No pulse is emitted on reset or on its release.
- Input held constant through reset release: if the post-invert value is 1, the channel debounces to 1 normally after release. That transition produces one `rise_o` pulse.

## Test plan
Configuration for all scenarios: NumIn=4, SyncStages=2, DebounceCycles=4, InvertMask=4'b1000.
- Reset, `raw_i`=4'b1000 held → `level_o`=0 and `irq_o`=0 for 20 cycles after reset release; no pulses.
- `raw_i[0]` 0→1 at edge E and held → `level_o[0]`=1 at E+6; `rise_o[0]` high only in that cycle; `event_o[0]`=1 at E+7.
- `raw_i[1]` high for 3 cycles then low → `level_o[1]` stays 0 and `rise_o[1]` never pulses. Repeat with a 5-cycle pulse → `level_o[1]` goes high; it then falls 6 cycles after `raw_i[1]` drops, with a single `fall_o[1]` pulse.
- `raw_i[3]` 1→0 (active-low press) → `level_o[3]` 0→1 after 6 cycles and `rise_o[3]` pulses. With `irq_en_i`=4'b1000, `irq_o`=1. Pulse `event_clr_i[3]` → `irq_o`=0 the next cycle.
- `event_clr_i[0]` asserted in the same cycle as `rise_o[0]` → `event_o[0]`=1 (set wins).
- Assert `rst_sys_ni`=0 with channel 2 in WAIT_HI at count 3 → all outputs 0 immediately. After release, with `raw_i[2]`=1 held, the first `rise_o[2]` pulse occurs no earlier than 6 cycles after release.
